uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial-to-parallel UART receiver, 8N1, LSB first.
- Consumes the serial line driven by the team's UART transmitter, either over the board pin or in the internal loopback.
- Presents each received byte on a valid/ready handshake to the downstream command/packet logic.
- Flags framing errors and overruns; shares CLK_HZ/BAUD conventions with the transmitter so a tx→rx loopback is bit-exact.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- Derived: DIV = CLK_HZ/BAUD (integer divide; 434 at defaults); HALF = DIV/2 (217 at defaults).
- Elaboration must fail if DIV < 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line, idle high.
- data  out  8  received byte; stable while valid=1.
- valid  out  1  byte available; held until accepted.
- ready  in  1  downstream accepts when valid&&ready at a clk edge.
- busy  out  1  high whenever the FSM is not in IDLE.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: byte completed while the previous byte was still held.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (rst).
- Reset values:
  - state=IDLE; data=0; valid=0; frame_err=0; overrun=0; busy=0.
  - Both synchronizer flops =1.
  - Bit counter and divider counter =0.
- Synchronizer:
  - rx passes through 2 flops to give rx_s; all FSM decisions use rx_s only.
  - Latency is 2 edges.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - rx_s==0 → START, cnt<=HALF-1.
- START:
  - cnt decrements each cycle.
  - At cnt==0, if rx_s==0 → DATA, cnt<=DIV-1, bitn<=0.
  - At cnt==0, if rx_s==1 → IDLE (glitch rejected, no flag).
- DATA:
  - At cnt==0: shift sh<={rx_s,sh[7:1]}, bitn<=bitn+1, cnt<=DIV-1.
  - After the 8th sample (bitn==7) → STOP.
- STOP, at cnt==0:
  - rx_s==1, valid==0 or ready==1 this cycle: data<=sh, valid<=1 → IDLE.
  - rx_s==1, valid==1 and ready==0: byte dropped, held data untouched, overrun pulses 1 cycle → IDLE.
  - rx_s==0: byte discarded, frame_err pulses 1 cycle → WAIT_HIGH.
- WAIT_HIGH:
  - Remains until rx_s==1, then → IDLE. A break or stuck-low line yields exactly one frame_err.
- Sample timing:
  - Let E0 be the first edge at which rx is captured low.
  - Start-bit mid sample at E0+2+HALF.
  - Data bit k sampled at E0+2+HALF+(k+1)·DIV.
  - Stop bit sampled at E0+2+HALF+9·DIV; valid/flags are visible after that edge (4125 cycles at defaults).
- Handshake:
  - valid&&ready clears valid at that edge.
  - Delivery and acceptance on the same edge: the new byte loads and valid stays 1; this is not an overrun.
  - ready is ignored while valid=0.
- Back-to-back frames: a start edge is accepted in IDLE immediately after the STOP sample, so there are no idle cycles between frames.
- Reset mid-frame: FSM returns to IDLE and the partial byte is lost. A line still low after reset is treated as a start bit only if low at the START mid-sample.
- Counters:
  - cnt width is $clog2(DIV); bitn is 3 bits.
  - Neither counter wraps outside its state.

Decomposition:
- Package uart_pkg:
  - typedef enum rx_state_t {IDLE,START,DATA,STOP,WAIT_HIGH}.
  - Function computing DIV/HALF from CLK_HZ, BAUD.
  - Constant UART_DATA_W=8.
  - Shared with the transmitter.
- Sub-module sync_2ff: parameterized reset value (1 here), reused for other async inputs.

Test Plan:
- Bench runs at CLK_HZ=16, BAUD=1 (DIV=16, HALF=8), ready=1.
- Single byte: drive 0xA5 frame → data=0xA5, valid high exactly at E0+2+8+144=E0+154, one cycle; frame_err=0, overrun=0.
- Glitch: rx low 3 cycles then high → FSM returns to IDLE at E0+10; valid, frame_err, overrun stay 0; busy pulses only during START.
- Framing: 0x3C frame with stop bit 0, then line held low 50 cycles → exactly one frame_err pulse, valid=0. Subsequent 0x81 frame received correctly after the line returns high.
- Overrun and handshake:
  - ready=0; send 0x11 then 0x22 back-to-back → data stays 0x11, valid=1, overrun pulses once at the second stop sample.
  - Raise ready → valid drops next edge.
  - Repeat with ready asserted on the exact delivery edge of 0x22 → data=0x22, no overrun.
- Loopback: uart_tx → uart_rx at defaults; bytes 0x00, 0xFF, 0x55, 0xAA, plus 256 random bytes → all received in order, no flags.
- Reset: assert rst mid-DATA of 0x5A for 1 cycle → all outputs at reset values next edge; a full 0xC3 frame sent afterwards is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   UART_DATA_W  - payload width of one character (8N1 framing)
//   rx_state_t   - receiver FSM state encoding
//   uart_div()   - clocks per bit, CLK_HZ/BAUD (integer divide)
//   uart_half()  - clocks from start-bit edge to its mid-point, DIV/2
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    function automatic int unsigned uart_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_hz / baud;
    endfunction

    function automatic int unsigned uart_half(input int unsigned clk_hz,
                                              input int unsigned baud);
        return uart_div(clk_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
//   clk - destination clock
//   rst - synchronous active-high reset, loads RST_VAL into both flops
//   d   - asynchronous input
//   q   - synchronized output, two clk edges behind d
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, with valid/ready byte output.
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   rx        - asynchronous serial line, idle high
//   data      - received byte, stable while valid is high
//   valid     - byte available, held until accepted
//   ready     - downstream accepts on valid && ready at a clk edge
//   busy      - receiver FSM is not idle
//   frame_err - one-cycle pulse: stop bit sampled low
//   overrun   - one-cycle pulse: byte completed while previous still held
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    output logic [UART_DATA_W-1:0] data,
    output logic                   valid,
    input  logic                   ready,
    output logic                   busy,
    output logic                   frame_err,
    output logic                   overrun
);

    localparam int unsigned DIV   = uart_div(CLK_HZ, BAUD);
    localparam int unsigned HALF  = uart_half(CLK_HZ, BAUD);
    localparam int unsigned CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DIV < 4) begin : g_div_check
        $error("uart_rx: CLK_HZ/BAUD must be at least 4");
    end

    rx_state_t              state, state_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic [2:0]             bitn, bitn_nx;
    logic [UART_DATA_W-1:0] sh, sh_nx;
    logic [UART_DATA_W-1:0] data_nx;
    logic                   valid_nx;
    logic                   frame_err_nx;
    logic                   overrun_nx;
    logic                   rx_s;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bitn      <= '0;
            sh        <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            bitn      <= bitn_nx;
            sh        <= sh_nx;
            data      <= data_nx;
            valid     <= valid_nx;
            frame_err <= frame_err_nx;
            overrun   <= overrun_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        bitn_nx      = bitn;
        sh_nx        = sh;
        data_nx      = data;
        valid_nx     = valid;
        frame_err_nx = 1'b0;
        overrun_nx   = 1'b0;

        // Acceptance first; a delivery on the same edge below re-asserts valid.
        if (valid && ready) begin
            valid_nx = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx = START;
                    cnt_nx   = CNT_HALF;
                end
            end

            START: begin
                if (cnt == '0) begin
                    if (!rx_s) begin
                        state_nx = DATA;
                        cnt_nx   = CNT_BIT;
                        bitn_nx  = '0;
                    end else begin
                        // Start bit gone by mid-point: treat as line noise.
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end

            DATA: begin
                if (cnt == '0) begin
                    sh_nx   = {rx_s, sh[UART_DATA_W-1:1]};
                    bitn_nx = bitn + 3'd1;
                    cnt_nx  = CNT_BIT;
                    if (bitn == 3'd7) begin
                        state_nx = STOP;
                    end
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end

            STOP: begin
                if (cnt == '0) begin
                    if (rx_s) begin
                        if (!valid || ready) begin
                            data_nx  = sh;
                            valid_nx = 1'b1;
                        end else begin
                            overrun_nx = 1'b1;
                        end
                        state_nx = IDLE;
                    end else begin
                        frame_err_nx = 1'b1;
                        state_nx     = WAIT_HIGH;
                    end
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end

            WAIT_HIGH: begin
                // Hold off until the line recovers so a break flags only once.
                if (rx_s) begin
                    state_nx = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at CLK_HZ=16, BAUD=1 (16 clocks
// per bit, start mid-point 8 clocks in). A behavioural 8N1 transmitter drives
// rx; expected bytes are queued as frames are sent and compared by a monitor
// whenever the receiver presents a new byte.
module tb_uart_rx;

    localparam int unsigned DIV = 16;
    localparam int unsigned LAT = 2 + 8 + 9 * DIV;  // E0 to stop-bit sample

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    uart_rx #(
        .CLK_HZ(16),
        .BAUD  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .busy     (busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and event counters, sampled on the falling edge.
    logic [7:0]  exp_q[$];
    logic [7:0]  sb_exp;
    int unsigned deliv_cnt = 0, fe_cnt = 0, ov_cnt = 0, busy_cnt = 0, valid_cnt = 0;
    int unsigned last_deliv = 0, last_fe = 0, last_ov = 0, last_busy = 0;
    logic        pv = 1'b0, pacc = 1'b0;

    always @(negedge clk) begin
        // New byte: valid rises, or a byte lands on the edge that accepted the old one.
        if (valid === 1'b1 && (!pv || pacc)) begin
            deliv_cnt++;
            last_deliv = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got byte %02h, none expected", data);
            end else begin
                sb_exp = exp_q.pop_front();
                if (data !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_data: got %02h, expected %02h", data, sb_exp);
                end
            end
        end
        if (valid === 1'b1) valid_cnt++;
        if (frame_err === 1'b1) begin fe_cnt++; last_fe = cyc; end
        if (overrun === 1'b1) begin ov_cnt++; last_ov = cyc; end
        if (busy === 1'b1) begin busy_cnt++; last_busy = cyc; end
        pacc = (valid === 1'b1) && (ready === 1'b1);
        pv   = (valid === 1'b1);
    end

    // All stimulus is aligned to 1 time unit after a rising edge.
    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopv,
                              output int unsigned e0);
        logic [9:0] f;
        f  = {stopv, b, 1'b0};
        e0 = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            tick(DIV);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; rx = 1'b1; ready = 1'b1;
        tick(3);
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h, expected 00", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_single;
        int unsigned e0, d0, v0, f0, o0;
        d0 = deliv_cnt; v0 = valid_cnt; f0 = fe_cnt; o0 = ov_cnt;
        ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, e0);
        tick(4);
        checks++; if (deliv_cnt !== d0 + 1) begin errors++; $display("FAIL single_count: got %0d, expected %0d", deliv_cnt - d0, 1); end
        checks++; if (last_deliv !== e0 + LAT) begin errors++; $display("FAIL single_latency: got cycle %0d, expected %0d", last_deliv, e0 + LAT); end
        checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL single_valid_width: got %0d cycles, expected 1", valid_cnt - v0); end
        checks++; if (fe_cnt !== f0 || ov_cnt !== o0) begin errors++; $display("FAIL single_flags: got fe=%0d ov=%0d, expected 0 0", fe_cnt - f0, ov_cnt - o0); end
    endtask

    task automatic test_glitch;
        int unsigned e0, d0, f0, o0, b0;
        d0 = deliv_cnt; f0 = fe_cnt; o0 = ov_cnt; b0 = busy_cnt;
        rx = 1'b0;
        e0 = cyc + 1;
        tick(3);
        rx = 1'b1;
        tick(20);
        checks++; if (busy_cnt !== b0 + 8) begin errors++; $display("FAIL glitch_busy_len: got %0d, expected 8", busy_cnt - b0); end
        checks++; if (last_busy !== e0 + 9) begin errors++; $display("FAIL glitch_idle_at: got last busy %0d, expected %0d", last_busy, e0 + 9); end
        checks++; if (deliv_cnt !== d0 || fe_cnt !== f0 || ov_cnt !== o0) begin errors++; $display("FAIL glitch_quiet: got deliv=%0d fe=%0d ov=%0d, expected 0 0 0", deliv_cnt - d0, fe_cnt - f0, ov_cnt - o0); end
    endtask

    task automatic test_framing;
        int unsigned e0, e1, d0, f0;
        d0 = deliv_cnt; f0 = fe_cnt;
        send_frame(8'h3C, 1'b0, e0);
        tick(50);
        rx = 1'b1;
        tick(6);
        checks++; if (fe_cnt !== f0 + 1) begin errors++; $display("FAIL frame_err_count: got %0d, expected 1", fe_cnt - f0); end
        checks++; if (last_fe !== e0 + LAT) begin errors++; $display("FAIL frame_err_time: got %0d, expected %0d", last_fe, e0 + LAT); end
        checks++; if (deliv_cnt !== d0 || valid !== 1'b0) begin errors++; $display("FAIL frame_no_byte: got deliv=%0d valid=%b, expected 0 0", deliv_cnt - d0, valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_recover: got busy=%b, expected 0", busy); end
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, e1);
        tick(4);
        checks++; if (last_deliv !== e1 + LAT) begin errors++; $display("FAIL frame_next_byte: got cycle %0d, expected %0d", last_deliv, e1 + LAT); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL frame_queue: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_overrun;
        int unsigned e0, e1, e1b, o0;
        o0 = ov_cnt;
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, e0);
        send_frame(8'h22, 1'b1, e1);
        tick(4);
        checks++; if (ov_cnt !== o0 + 1) begin errors++; $display("FAIL ovr_count: got %0d, expected 1", ov_cnt - o0); end
        checks++; if (last_ov !== e1 + LAT) begin errors++; $display("FAIL ovr_time: got %0d, expected %0d", last_ov, e1 + LAT); end
        checks++; if (data !== 8'h11 || valid !== 1'b1) begin errors++; $display("FAIL ovr_hold: got data=%02h valid=%b, expected 11 1", data, valid); end
        ready = 1'b1;
        tick(1);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_accept: got valid=%b, expected 0", valid); end

        // Second pair: acceptance coincides with the 0x22 stop sample.
        ready = 1'b0;
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1, e0);
        e1 = cyc + 1;
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1, e1b);
            begin
                while (cyc != e1 + LAT - 1) tick(1);
                ready = 1'b1;
            end
        join
        tick(4);
        checks++; if (ov_cnt !== o0 + 1) begin errors++; $display("FAIL same_edge_overrun: got %0d, expected 0 new", ov_cnt - o0 - 1); end
        checks++; if (last_deliv !== e1b + LAT) begin errors++; $display("FAIL same_edge_time: got %0d, expected %0d", last_deliv, e1b + LAT); end
        checks++; if (data !== 8'h22 || valid !== 1'b0) begin errors++; $display("FAIL same_edge_data: got data=%02h valid=%b, expected 22 0", data, valid); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovr_queue: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        int unsigned e0, d0, f0, o0;
        logic [7:0] fixed [4];
        logic [7:0] b;
        fixed[0] = 8'h00; fixed[1] = 8'hFF; fixed[2] = 8'h55; fixed[3] = 8'hAA;
        d0 = deliv_cnt; f0 = fe_cnt; o0 = ov_cnt;
        ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            b = (i < 4) ? fixed[i] : 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, e0);
        end
        tick(4);
        checks++; if (deliv_cnt !== d0 + 260) begin errors++; $display("FAIL b2b_count: got %0d, expected 260", deliv_cnt - d0); end
        checks++; if (fe_cnt !== f0 || ov_cnt !== o0) begin errors++; $display("FAIL b2b_flags: got fe=%0d ov=%0d, expected 0 0", fe_cnt - f0, ov_cnt - o0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_queue: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_midframe;
        int unsigned e0, d0, f0;
        logic [7:0] b;
        b = 8'h5A;
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            tick(DIV);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b, expected 1", busy); end
        rst = 1'b1;
        tick(1);
        checks++; if (data !== 8'h00 || valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: got data=%02h valid=%b busy=%b fe=%b ov=%b, expected 00 0 0 0 0", data, valid, busy, frame_err, overrun);
        end
        rst = 1'b0;
        rx  = 1'b1;
        d0 = deliv_cnt; f0 = fe_cnt;
        tick(20);
        checks++; if (deliv_cnt !== d0 || fe_cnt !== f0 || busy !== 1'b0) begin errors++; $display("FAIL midframe_quiet: got deliv=%0d fe=%0d busy=%b, expected 0 0 0", deliv_cnt - d0, fe_cnt - f0, busy); end
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, e0);
        tick(4);
        checks++; if (last_deliv !== e0 + LAT) begin errors++; $display("FAIL midframe_next: got cycle %0d, expected %0d", last_deliv, e0 + LAT); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midframe_queue: got %0d pending, expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
